u712_byte_lane_sequencer: RTL

- Parametrised successor to the U712 byte-enable decode.
- Takes one 68040-style host transfer request (SIZ, A) on a HOST_BYTES-wide bus and runs it as a sequence of narrower port cycles, for example 16-bit chipset cycles on a 32-bit host bus.
- Drives host lane enables and port data strobes for each slice; handshakes each slice with port ACKn.
- Adds line (burst) beat counting and abort handling that the combinational decode does not have.

---
 rtl/u712_byte_lane_sequencer_if.sv | 24 ++
 rtl/u712_byte_lane_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/u712_byte_lane_sequencer_if.sv
// u712_byte_lane_sequencer_if: host request (START/SIZ/A/ABORT), port ACKn in; BEn/PORT_BEn/PORT_OFS/BEAT/BUSY/DONE out
interface u712_byte_lane_sequencer_if #(
  parameter int HOST_BYTES = 4,
  parameter int PORT_BYTES = 2,
  parameter int LINE_BEATS = 4
);
  localparam int AW = $clog2(HOST_BYTES);
  localparam int NS = HOST_BYTES / PORT_BYTES;
  localparam int OW = NS > 1 ? $clog2(NS) : 1;
  localparam int BW = LINE_BEATS > 1 ? $clog2(LINE_BEATS) : 1;
  logic START;
  logic [1:0] SIZ;
  logic [AW-1:0] A;
  logic ACKn;
  logic ABORT;
  logic [HOST_BYTES-1:0] BEn;
  logic [PORT_BYTES-1:0] PORT_BEn;
  logic [OW-1:0] PORT_OFS;
  logic [BW-1:0] BEAT;
  logic BUSY;
  logic DONE;
  modport master (output START, SIZ, A, ACKn, ABORT, input BEn, PORT_BEn, PORT_OFS, BEAT, BUSY, DONE);
  modport slave (input START, SIZ, A, ACKn, ABORT, output BEn, PORT_BEn, PORT_OFS, BEAT, BUSY, DONE);
endinterface

// File: rtl/u712_byte_lane_sequencer.sv
// u712_byte_lane_sequencer: splits a 68040 host transfer into narrower ACKn-handshaked port cycles; ports CLK40, RESETn, bus (slave modport)
module u712_byte_lane_sequencer #(
  parameter int HOST_BYTES = 4,
  parameter int PORT_BYTES = 2,
  parameter int LINE_BEATS = 4
) (
  input logic CLK40,
  input logic RESETn,
  u712_byte_lane_sequencer_if.slave bus
);
  localparam int AW = $clog2(HOST_BYTES);
  localparam int NS = HOST_BYTES / PORT_BYTES;
  localparam int OW = NS > 1 ? $clog2(NS) : 1;
  localparam int BW = LINE_BEATS > 1 ? $clog2(LINE_BEATS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RECOVER, S_FIN} state_t;
  state_t state;
  logic [HOST_BYTES-1:0] mask, req_mask, ben;
  logic [PORT_BYTES-1:0] port_ben;
  logic [OW-1:0] ptr, ofs;
  logic [BW-1:0] beat;
  logic line, busy, done;
  int req_k, nxt_k, top_k;
  function automatic logic [PORT_BYTES-1:0] slice_of(input logic [HOST_BYTES-1:0] m, input int k);
    for (int j = 0; j < PORT_BYTES; j++) slice_of[j] = m[k*PORT_BYTES+j];
  endfunction
  function automatic logic [HOST_BYTES-1:0] lanes_of(input logic [HOST_BYTES-1:0] m, input int k);
    for (int i = 0; i < HOST_BYTES; i++) lanes_of[i] = m[i] && (i / PORT_BYTES == k);
  endfunction
  function automatic int first_from(input logic [HOST_BYTES-1:0] m, input int s);
    first_from = -1;
    for (int k = NS - 1; k >= 0; k--) if (k >= s && |slice_of(m, k)) first_from = k;
  endfunction
  always_comb begin
    req_mask = bus.SIZ == 2'b01 ? HOST_BYTES'(1) << bus.A :
               bus.SIZ == 2'b10 ? HOST_BYTES'(3) << (bus.A & ~AW'(1)) : '1;
    req_k = first_from(req_mask, 0);
    nxt_k = first_from(mask, int'(ptr) + 1);
    top_k = first_from(mask, 0);
  end
  always_ff @(posedge CLK40 or negedge RESETn)
    if (!RESETn) begin
      state <= S_IDLE;
      mask <= '0;
      line <= 1'b0;
      ptr <= '0;
      beat <= '0;
      ben <= '1;
      port_ben <= '1;
      ofs <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == S_ACTIVE || state == S_RECOVER) && bus.ABORT) begin
        state <= S_IDLE;
        ben <= '1;
        port_ben <= '1;
        ofs <= '0;
        beat <= '0;
        busy <= 1'b0;
      end else
        case (state)
          S_IDLE:
            if (bus.START) begin
              state <= S_ACTIVE;
              mask <= req_mask;
              line <= bus.SIZ == 2'b11;
              ptr <= OW'(req_k);
              beat <= '0;
              ben <= ~lanes_of(req_mask, req_k);
              port_ben <= ~slice_of(req_mask, req_k);
              ofs <= OW'(req_k);
              busy <= 1'b1;
            end
          S_ACTIVE:
            if (!bus.ACKn) begin
              ben <= '1;
              port_ben <= '1;
              if (nxt_k >= 0) begin
                state <= S_RECOVER;
                ptr <= OW'(nxt_k);
              end else if (line && int'(beat) < LINE_BEATS - 1) begin
                state <= S_RECOVER;
                beat <= beat + 1'b1;
                ptr <= OW'(top_k);
              end else begin
                state <= S_FIN;
                done <= 1'b1;
                beat <= '0;
              end
            end
          S_RECOVER: begin
            state <= S_ACTIVE;
            ben <= ~lanes_of(mask, int'(ptr));
            port_ben <= ~slice_of(mask, int'(ptr));
            ofs <= ptr;
          end
          default: begin
            state <= S_IDLE;
            busy <= 1'b0;
            ofs <= '0;
          end
        endcase
    end
  assign bus.BEn = ben;
  assign bus.PORT_BEn = port_ben;
  assign bus.PORT_OFS = ofs;
  assign bus.BEAT = beat;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
endmodule
